// File: rtl/stage_sequencer.sv
// ----------------------------------------------------------------------------
// stage_sequencer
//   Loads a program into an external program memory through a valid/ready
//   stream, then steps a simple FETCH -> DECODE -> EXECUTE processor cycle.
//   A reload request that is still high when an EXECUTE is left returns the
//   block to loading. The block counts completed EXECUTE cycles and remembers
//   the length of the last completed program load.
// ----------------------------------------------------------------------------
module stage_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              run_en,
   input  logic              reload,
   output logic [1:0]        stage,
   output logic              pm_we,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [DATA_W-1:0] pm_wdata,
   output logic [ADDR_W:0]   prog_len,
   output logic [15:0]       exec_count
);

   // Sequencer states; both load states report stage 00.
   typedef enum logic [2:0] {
      ST_LOAD_ACCEPT = 3'd0,
      ST_LOAD_FLUSH  = 3'd1,
      ST_FETCH       = 3'd2,
      ST_DECODE      = 3'd3,
      ST_EXECUTE     = 3'd4
   } state_t;

   // Externally visible stage encodings.
   localparam logic [1:0] STAGE_LOAD    = 2'b00;
   localparam logic [1:0] STAGE_FETCH   = 2'b01;
   localparam logic [1:0] STAGE_DECODE  = 2'b10;
   localparam logic [1:0] STAGE_EXECUTE = 2'b11;

   // Pointer value of the last memory location; a transfer here fills memory.
   localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [15:0]     EXEC_MAX  = 16'hFFFF;

   // Map an internal state onto the two-bit stage code.
   function automatic logic [1:0] stage_of(input state_t st);
      logic [1:0] code;
      case (st)
         ST_LOAD_ACCEPT: code = STAGE_LOAD;
         ST_LOAD_FLUSH:  code = STAGE_LOAD;
         ST_FETCH:       code = STAGE_FETCH;
         ST_DECODE:      code = STAGE_DECODE;
         ST_EXECUTE:     code = STAGE_EXECUTE;
         default:        code = STAGE_LOAD;
      endcase
      return code;
   endfunction

   // Registered state and outputs.
   state_t              state_r;
   logic [1:0]          stage_r;
   logic [ADDR_W:0]     wr_ptr_r;
   logic                pm_we_r;
   logic [ADDR_W-1:0]   pm_addr_r;
   logic [DATA_W-1:0]   pm_wdata_r;
   logic [ADDR_W:0]     prog_len_r;
   logic [15:0]         exec_count_r;

   // Combinational control.
   state_t              state_next_s;
   logic                load_ready_s;
   logic                xfer_s;
   logic                full_s;
   logic                last_xfer_s;
   logic                leave_exec_s;
   logic                reload_take_s;

   // Handshake decode: ready depends only on state (and reset), never on valid.
   always_comb begin
      load_ready_s = 1'b0;
      if ((state_r == ST_LOAD_ACCEPT) && !rst) begin
         load_ready_s = 1'b1;
      end else begin
         load_ready_s = 1'b0;
      end
      xfer_s      = load_valid && load_ready_s;
      full_s      = (wr_ptr_r == LAST_ADDR);
      last_xfer_s = xfer_s && (load_last || full_s);
   end

   // Next-state logic; also flags the cycle in which EXECUTE is left.
   always_comb begin
      state_next_s  = state_r;
      leave_exec_s  = 1'b0;
      reload_take_s = 1'b0;
      case (state_r)
         ST_LOAD_ACCEPT: begin
            if (last_xfer_s) begin
               state_next_s = ST_LOAD_FLUSH;
            end else begin
               state_next_s = ST_LOAD_ACCEPT;
            end
         end
         ST_LOAD_FLUSH: begin
            state_next_s = ST_FETCH;
         end
         ST_FETCH: begin
            if (run_en) begin
               state_next_s = ST_DECODE;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (run_en) begin
               state_next_s = ST_EXECUTE;
            end else begin
               state_next_s = ST_DECODE;
            end
         end
         ST_EXECUTE: begin
            if (run_en) begin
               leave_exec_s = 1'b1;
               if (reload) begin
                  reload_take_s = 1'b1;
                  state_next_s  = ST_LOAD_ACCEPT;
               end else begin
                  state_next_s  = ST_FETCH;
               end
            end else begin
               state_next_s = ST_EXECUTE;
            end
         end
         default: begin
            state_next_s = ST_LOAD_ACCEPT;
         end
      endcase
   end

   // State register with the stage code registered alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_LOAD_ACCEPT;
         stage_r <= STAGE_LOAD;
      end else begin
         state_r <= state_next_s;
         stage_r <= stage_of(state_next_s);
      end
   end

   // Write pointer: advances per transfer, restarts at 0 on a reload.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
      end else if (xfer_s) begin
         wr_ptr_r <= wr_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
      end else if (reload_take_s) begin
         wr_ptr_r <= '0;
      end else begin
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Program memory write port, one cycle behind the accepted transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         pm_we_r    <= 1'b0;
         pm_addr_r  <= '0;
         pm_wdata_r <= '0;
      end else begin
         pm_we_r <= xfer_s;
         if (xfer_s) begin
            pm_addr_r  <= wr_ptr_r[ADDR_W-1:0];
            pm_wdata_r <= load_data;
         end else begin
            pm_addr_r  <= pm_addr_r;
            pm_wdata_r <= pm_wdata_r;
         end
      end
   end

   // Program length: captured once the final write of a load is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         prog_len_r <= '0;
      end else if (state_r == ST_LOAD_FLUSH) begin
         prog_len_r <= wr_ptr_r;
      end else begin
         prog_len_r <= prog_len_r;
      end
   end

   // Saturating count of completed EXECUTE cycles since the last load.
   always_ff @(posedge clk) begin
      if (rst) begin
         exec_count_r <= '0;
      end else if (state_r == ST_LOAD_FLUSH) begin
         exec_count_r <= '0;
      end else if (leave_exec_s && (exec_count_r != EXEC_MAX)) begin
         exec_count_r <= exec_count_r + 16'd1;
      end else begin
         exec_count_r <= exec_count_r;
      end
   end

   assign load_ready = load_ready_s;
   assign stage      = stage_r;
   assign pm_we      = pm_we_r;
   assign pm_addr    = pm_addr_r;
   assign pm_wdata   = pm_wdata_r;
   assign prog_len   = prog_len_r;
   assign exec_count = exec_count_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// ----------------------------------------------------------------------------
// tb_stage_sequencer
//   Directed bench for stage_sequencer. Inputs change 1 time unit after each
//   rising edge; outputs are checked at that same point, reflecting the edge.
// ----------------------------------------------------------------------------
module tb_stage_sequencer;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 12;

   logic              clk;
   logic              rst;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              run_en;
   logic              reload;
   logic [1:0]        stage;
   logic              pm_we;
   logic [ADDR_W-1:0] pm_addr;
   logic [DATA_W-1:0] pm_wdata;
   logic [ADDR_W:0]   prog_len;
   logic [15:0]       exec_count;

   int checks;
   int failures;

   stage_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .run_en     (run_en),
      .reload     (reload),
      .stage      (stage),
      .pm_we      (pm_we),
      .pm_addr    (pm_addr),
      .pm_wdata   (pm_wdata),
      .prog_len   (prog_len),
      .exec_count (exec_count)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Directed stimulus sequence.
   initial begin
      logic [1:0] run_stages [9];
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 12'h000;
      load_last  = 1'b0;
      run_en     = 1'b0;
      reload     = 1'b0;
      run_stages[0] = 2'b10; run_stages[1] = 2'b11; run_stages[2] = 2'b01;
      run_stages[3] = 2'b10; run_stages[4] = 2'b11; run_stages[5] = 2'b01;
      run_stages[6] = 2'b10; run_stages[7] = 2'b11; run_stages[8] = 2'b01;

      // ---- reset state
      tick();
      tick();
      chk("rst_stage", 32'(stage), 32'd0);
      chk("rst_pm_we", 32'(pm_we), 32'd0);
      chk("rst_pm_addr", 32'(pm_addr), 32'd0);
      chk("rst_pm_wdata", 32'(pm_wdata), 32'd0);
      chk("rst_prog_len", 32'(prog_len), 32'd0);
      chk("rst_exec_count", 32'(exec_count), 32'd0);
      chk("rst_ready_low", 32'(load_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(load_ready), 32'd1);

      // ---- three-word load ending with load_last
      load_valid = 1'b1; load_data = 12'h8A1;
      tick();
      chk("l3_we0", 32'(pm_we), 32'd1);
      chk("l3_addr0", 32'(pm_addr), 32'd0);
      chk("l3_data0", 32'(pm_wdata), 32'h8A1);
      load_data = 12'h402;
      tick();
      chk("l3_we1", 32'(pm_we), 32'd1);
      chk("l3_addr1", 32'(pm_addr), 32'd1);
      chk("l3_data1", 32'(pm_wdata), 32'h402);
      load_data = 12'h1FF; load_last = 1'b1;
      tick();
      chk("l3_we2", 32'(pm_we), 32'd1);
      chk("l3_addr2", 32'(pm_addr), 32'd2);
      chk("l3_data2", 32'(pm_wdata), 32'h1FF);
      chk("flush_stage", 32'(stage), 32'd0);
      chk("flush_ready", 32'(load_ready), 32'd0);
      load_valid = 1'b0; load_last = 1'b0;
      tick();
      chk("l3_fetch", 32'(stage), 32'd1);
      chk("l3_prog_len", 32'(prog_len), 32'd3);
      chk("l3_we_off", 32'(pm_we), 32'd0);
      chk("l3_exec0", 32'(exec_count), 32'd0);

      // ---- load inputs ignored outside LOAD_ACCEPT; run_en=0 holds FETCH
      load_valid = 1'b1; load_data = 12'h777;
      tick();
      chk("ign_we", 32'(pm_we), 32'd0);
      chk("ign_ready", 32'(load_ready), 32'd0);
      chk("hold_fetch", 32'(stage), 32'd1);
      load_valid = 1'b0;

      // ---- run nine cycles, then park in DECODE with run_en=0
      run_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("run_stage%0d", i), 32'(stage), 32'(run_stages[i]));
      end
      chk("run_exec3", 32'(exec_count), 32'd3);
      tick();
      chk("to_decode", 32'(stage), 32'd2);
      run_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("park_stage%0d", i), 32'(stage), 32'd2);
         chk($sformatf("park_exec%0d", i), 32'(exec_count), 32'd3);
      end

      // ---- reload in FETCH only has no effect
      run_en = 1'b1;
      tick();                                   // EXECUTE
      tick();                                   // FETCH
      chk("exec4", 32'(exec_count), 32'd4);
      reload = 1'b1;
      tick();                                   // DECODE
      reload = 1'b0;
      tick();                                   // EXECUTE
      tick();
      chk("fetch_reload_noeffect", 32'(stage), 32'd1);
      chk("exec5", 32'(exec_count), 32'd5);

      // ---- reload held through DECODE and EXECUTE returns to LOAD
      tick();                                   // DECODE
      reload = 1'b1;
      tick();                                   // EXECUTE
      tick();                                   // LOAD_ACCEPT
      reload = 1'b0;
      chk("reload_stage", 32'(stage), 32'd0);
      chk("reload_ready", 32'(load_ready), 32'd1);
      chk("reload_exec6", 32'(exec_count), 32'd6);
      chk("reload_prog_len_kept", 32'(prog_len), 32'd3);
      run_en = 1'b0;

      // ---- toggling-valid load: 4 words, gaps in between
      load_valid = 1'b1; load_data = 12'h111;
      tick();
      chk("tg_we0", 32'(pm_we), 32'd1);
      chk("tg_addr0", 32'(pm_addr), 32'd0);
      chk("tg_data0", 32'(pm_wdata), 32'h111);
      load_valid = 1'b0;
      tick();
      chk("tg_gap0_we", 32'(pm_we), 32'd0);
      chk("tg_gap0_ready", 32'(load_ready), 32'd1);
      load_valid = 1'b1; load_data = 12'h222;
      tick();
      chk("tg_we1", 32'(pm_we), 32'd1);
      chk("tg_addr1", 32'(pm_addr), 32'd1);
      load_valid = 1'b0; load_last = 1'b1;      // last without transfer: ignored
      tick();
      chk("tg_gap1_we", 32'(pm_we), 32'd0);
      chk("tg_gap1_ready", 32'(load_ready), 32'd1);
      load_valid = 1'b1; load_data = 12'h333; load_last = 1'b0;
      tick();
      chk("tg_addr2", 32'(pm_addr), 32'd2);
      chk("tg_data2", 32'(pm_wdata), 32'h333);
      load_valid = 1'b0;
      tick();
      chk("tg_gap2_ready", 32'(load_ready), 32'd1);
      load_valid = 1'b1; load_data = 12'h444; load_last = 1'b1;
      tick();
      chk("tg_we3", 32'(pm_we), 32'd1);
      chk("tg_addr3", 32'(pm_addr), 32'd3);
      chk("tg_flush_prog_len_old", 32'(prog_len), 32'd3);
      load_valid = 1'b0; load_last = 1'b0;
      tick();
      chk("tg_fetch", 32'(stage), 32'd1);
      chk("tg_prog_len", 32'(prog_len), 32'd4);
      chk("tg_exec_cleared", 32'(exec_count), 32'd0);

      // ---- return to LOAD for a full-memory load
      run_en = 1'b1; reload = 1'b1;
      tick();
      tick();
      tick();
      run_en = 1'b0; reload = 1'b0;
      chk("full_entry_stage", 32'(stage), 32'd0);
      load_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         load_data = 12'((i * 7) ^ 12'h5A5);
         chk($sformatf("full_ready%0d", i), 32'(load_ready), 32'd1);
         tick();
         chk($sformatf("full_addr%0d", i), 32'(pm_addr), 32'(i));
         chk($sformatf("full_data%0d", i), 32'(pm_wdata), 32'(12'((i * 7) ^ 12'h5A5)));
      end
      chk("full_flush_we", 32'(pm_we), 32'd1);
      chk("full_flush_ready", 32'(load_ready), 32'd0);
      chk("full_flush_stage", 32'(stage), 32'd0);
      load_data = 12'hFFF;                      // 257th word stays offered
      tick();
      chk("full_257_not_written", 32'(pm_we), 32'd0);
      chk("full_fetch", 32'(stage), 32'd1);
      chk("full_prog_len", 32'(prog_len), 32'd256);
      load_valid = 1'b0;

      // ---- reset in the middle of a load
      run_en = 1'b1; reload = 1'b1;
      tick();
      tick();
      tick();
      run_en = 1'b0; reload = 1'b0;
      load_valid = 1'b1; load_data = 12'hAAA;
      tick();
      load_data = 12'hBBB;
      tick();
      chk("mid_addr1", 32'(pm_addr), 32'd1);
      rst = 1'b1; load_data = 12'hCCC;
      #1;
      chk("mid_rst_ready", 32'(load_ready), 32'd0);
      tick();
      chk("mid_rst_we", 32'(pm_we), 32'd0);
      chk("mid_rst_stage", 32'(stage), 32'd0);
      chk("mid_rst_prog_len", 32'(prog_len), 32'd0);
      chk("mid_rst_exec", 32'(exec_count), 32'd0);
      rst = 1'b0; load_data = 12'hDDD;
      tick();
      chk("mid_restart_we", 32'(pm_we), 32'd1);
      chk("mid_restart_addr", 32'(pm_addr), 32'd0);
      chk("mid_restart_data", 32'(pm_wdata), 32'hDDD);
      load_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
